keypad_key_controller: RTL
==========================

# keypad_key_controller

- Sequences the keypad scanner.
- Freezes column scanning once the scanner reports a press, then debounces the press.
- Registers exactly one key event per physical press, then waits for a debounced release before scanning resumes.
- Sits between the scanner and the two-digit display logic. Supplies the decoded hex key, a one-cycle event strobe and the two most recent keys.

## Interface
Parameters:
- None; debounce length is a runtime port, as for the scanner.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- key_press  input  1  scanner raw press flag (any row active on the driven column)
- R_press  input  4  scanner row snapshot, one-hot when valid
- C  input  4  scanner column drive, one-hot
- bounce_cycle_wait  input  24  debounce length N in clk cycles
- scan_en  output  1  scanner may advance columns; low = hold current column
- new_key  output  1  one-cycle strobe, one per registered press
- key_val  output  4  hex code of the last registered key
- digit_hi  output  4  previous registered key
- digit_lo  output  4  most recent registered key
- press_count  output  8  registered-press counter, wraps 255 -> 0

## Operation
Key decode uses row index r and column index c, where the index is the position of the single set bit (bit 0 = index 0):
- r0: 1 2 3 A
- r1: 4 5 6 B
- r2: 7 8 9 C
- r3: E 0 F D

A code is valid only when both R_press and C are one-hot. Invalid codes are never registered.

FSM states: IDLE, DB_PRESS, REGISTER, HELD, DB_REL. The 24-bit debounce counter is named cnt.
- IDLE: scan_en=1. If key_press=1 and the code is valid -> DB_PRESS, capture {R_press,C}, cnt=0. Otherwise stay.
- DB_PRESS: scan_en=0.
  - key_press=0 or {R_press,C} != captured -> IDLE; nothing registered.
  - Else if cnt==N -> REGISTER.
  - Else cnt++.
- REGISTER: one cycle. new_key=1, scan_en=0, then -> HELD.
- HELD: scan_en=0. key_press=0 -> DB_REL, cnt=0.
- DB_REL: scan_en=0.
  - key_press=1 -> HELD, bounce; cnt discarded.
  - Else if cnt==N -> IDLE.
  - Else cnt++.

Register update happens on the edge DB_PRESS -> REGISTER:
- key_val <= code
- digit_lo <= code
- digit_hi <= old digit_lo
- press_count <= press_count+1, mod 256

Values are therefore already updated in the cycle new_key=1.

## Timing
- Reset (asynchronous, any state, including mid-debounce): state=IDLE, cnt=0, scan_en=1, new_key=0, key_val=0, digit_hi=0, digit_lo=0, press_count=0. No event is produced by a press aborted by reset.
- scan_en and new_key are Moore outputs decoded from state; no combinational path from inputs.
- Press latency: key_press sampled high in IDLE at edge k.
  - DB_PRESS occupies k+1 .. k+N+1, i.e. N+1 cycles.
  - REGISTER (new_key=1) occupies cycle k+N+2.
- N=0: a single DB_PRESS cycle; REGISTER at k+2.
- Release: after key_press falls in HELD, return to IDLE requires N+1 consecutive low samples in DB_REL. scan_en rises the cycle after.
- A held key never produces a second new_key, regardless of duration.
- A second key pressed while in HELD or DB_REL is ignored until IDLE is reached.
- A code change during DB_PRESS aborts to IDLE. It can be re-detected on the next IDLE cycle.
- press_count wrap: 255 + press -> 0. No saturation, no flag.
- cnt never exceeds N; all counter comparisons are 24-bit unsigned.

## Test plan
All scenarios use N=3.
1. Reset and key 5:
   - Stimulus: reset pulse, then R_press=0010, C=0010, key_press held high from edge k.
   - Required: scan_en=0 from k+1, new_key=1 only at k+5, key_val=5, digit_lo=5, digit_hi=0, press_count=1.
2. Bounce on press:
   - Stimulus: key_press high 2 cycles, low 1, high 6.
   - Required: the first attempt aborts to IDLE with no new_key; exactly one new_key on the second attempt.
3. Two presses with release:
   - Stimulus: key 1 (r0,c0), release 6 cycles, then key D (r3,c3).
   - Required: digit_hi=1, digit_lo=D, key_val=D, two new_key pulses total.
4. Release bounce:
   - Stimulus: in HELD, key_press low 2 cycles, high 1, low 5.
   - Required: no new_key; scan_en stays 0 until 4 consecutive DB_REL low cycles, then returns to 1.
5. Invalid code and asynchronous reset:
   - Stimulus: R_press=0110 with key_press=1 -> state stays IDLE, scan_en=1. Then assert reset mid-DB_PRESS.
   - Required: all outputs return to reset values immediately, with no new_key.
6. Counter wrap:
   - Stimulus: 256 clean presses of key 0 (r3,c1).
   - Required: press_count returns to 0, key_val=0, new_key count=256.

Source files
------------

// File: rtl/keypad_key_controller.sv
// Purpose: debounce keypad scanner presses and register one hex key event per physical press.
// Latency: new_key is asserted N+2 cycles after key_press is first sampled in IDLE (N = bounce_cycle_wait).
// Backpressure: scan_en drops to freeze the scanner column from press detection until the release is debounced.
module keypad_key_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_press,
  input  logic [3:0]  R_press,
  input  logic [3:0]  C,
  input  logic [23:0] bounce_cycle_wait,
  output logic        scan_en,
  output logic        new_key,
  output logic [3:0]  key_val,
  output logic [3:0]  digit_hi,
  output logic [3:0]  digit_lo,
  output logic [7:0]  press_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    REGISTER = 3'd2,
    HELD     = 3'd3,
    DB_REL   = 3'd4
  } state_t;

  state_t      state;
  logic [23:0] cnt;
  logic [7:0]  cap;        // captured {row, column} snapshot under debounce
  logic        code_valid;
  logic [3:0]  cap_code;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] bit_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Keypad layout lookup indexed by {row index, column index}
  function automatic logic [3:0] decode_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = 4'h0;
    case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;
      4'b11_01: k = 4'h0;
      4'b11_10: k = 4'hF;
      4'b11_11: k = 4'hD;
      default:  k = 4'h0;
    endcase
    return k;
  endfunction

  // Live-code validity check and decode of the captured snapshot
  always_comb begin
    code_valid = is_onehot(R_press) && is_onehot(C);
    cap_code   = decode_key(bit_index(cap[7:4]), bit_index(cap[3:0]));
  end

  // Press/release debounce FSM; scan_en and new_key are registered alongside the state they decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 24'd0;
      cap         <= 8'd0;
      scan_en     <= 1'b1;
      new_key     <= 1'b0;
      key_val     <= 4'd0;
      digit_hi    <= 4'd0;
      digit_lo    <= 4'd0;
      press_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (key_press && code_valid) begin
            state   <= DB_PRESS;
            cap     <= {R_press, C};
            cnt     <= 24'd0;
            scan_en <= 1'b0;
          end
        end
        DB_PRESS: begin
          if (!key_press || ({R_press, C} != cap)) begin
            // Bounce or different key: drop the attempt, nothing registered
            state   <= IDLE;
            scan_en <= 1'b1;
          end else if (cnt >= bounce_cycle_wait) begin
            // >= rather than == so a runtime shrink of N cannot strand the counter
            state       <= REGISTER;
            new_key     <= 1'b1;
            key_val     <= cap_code;
            digit_lo    <= cap_code;
            digit_hi    <= digit_lo;
            press_count <= press_count + 8'd1;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        REGISTER: begin
          state   <= HELD;
          new_key <= 1'b0;
        end
        HELD: begin
          if (!key_press) begin
            state <= DB_REL;
            cnt   <= 24'd0;
          end
        end
        DB_REL: begin
          if (key_press) begin
            // Release bounce: still held, never re-registers
            state <= HELD;
          end else if (cnt >= bounce_cycle_wait) begin
            state   <= IDLE;
            scan_en <= 1'b1;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        default: begin
          state   <= IDLE;
          scan_en <= 1'b1;
          new_key <= 1'b0;
        end
      endcase
    end
  end

endmodule
